// File: rtl/reorder_buffer_pkg.sv
// Shared constants, state type and capacity helper for the reorder buffer slice.
package reorder_buffer_pkg;

    localparam int RegWidth   = 5;
    localparam int IDWidth    = 32;
    localparam int DataWidth  = 32;
    localparam int ROBWidth   = 4;
    localparam int RobTagNone = 0;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } rob_state_e;

    // Tag 0 is reserved, so a W-bit tag space holds one entry fewer than 2^W.
    function automatic int rob_capacity(input int w);
        return (32'sd1 <<< w) - 32'sd1;
    endfunction

endpackage

// File: rtl/reorder_buffer_tag_ptr.sv
// Wrapping tag pointer for the reorder buffer: counts 1..2^W-1, never yields tag 0.
module rob_tag_ptr #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    localparam logic [W-1:0] TagFirst = W'(32'd1);
    localparam logic [W-1:0] TagLast  = {W{1'b1}};

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Next pointer: clear wins over increment.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = TagFirst;
        end else if (inc_i) begin
            ptr_d = (ptr_q == TagLast) ? TagFirst : (ptr_q + TagFirst);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= TagFirst;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order tag allocation, CDB capture, in-order retirement, mispredict flush.
// Optional macro ROB_BYPASS_EN forwards a same-cycle CDB broadcast to operand queries.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH  = ROBWidth,
    parameter int REG_WIDTH  = RegWidth,
    parameter int DATA_WIDTH = DataWidth,
    parameter int ADDR_WIDTH = IDWidth
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  dispatcher_rob_en_in,
    input  logic [REG_WIDTH-1:0]  dispatcher_rob_rd_in,
    input  logic                  dispatcher_rob_branch_in,
    input  logic                  dispatcher_rob_pred_in,
    output logic                  rob_dispatcher_full_out,
    output logic [ROB_WIDTH-1:0]  rob_dispatcher_tag_out,
    input  logic [ROB_WIDTH-1:0]  dispatcher_rob_qs_in,
    output logic                  rob_dispatcher_qs_ready_out,
    output logic [DATA_WIDTH-1:0] rob_dispatcher_qs_value_out,
    input  logic [ROB_WIDTH-1:0]  dispatcher_rob_qt_in,
    output logic                  rob_dispatcher_qt_ready_out,
    output logic [DATA_WIDTH-1:0] rob_dispatcher_qt_value_out,
    input  logic                  cdb_rob_en_in,
    input  logic [ROB_WIDTH-1:0]  cdb_rob_tag_in,
    input  logic [DATA_WIDTH-1:0] cdb_rob_value_in,
    input  logic                  cdb_rob_taken_in,
    input  logic [ADDR_WIDTH-1:0] cdb_rob_target_in,
    output logic                  rob_regfile_en_out,
    output logic [REG_WIDTH-1:0]  rob_regfile_d_out,
    output logic [DATA_WIDTH-1:0] rob_regfile_value_out,
    output logic [ROB_WIDTH-1:0]  rob_regfile_h_out,
    output logic                  rob_regfile_rst_out,
    output logic [ADDR_WIDTH-1:0] rob_fetcher_pc_out
);

    localparam int                   Depth    = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH-1:0] Capacity = ROB_WIDTH'(rob_capacity(ROB_WIDTH));
    localparam logic [ROB_WIDTH-1:0] TagNone  = ROB_WIDTH'(RobTagNone);
    localparam logic [ROB_WIDTH-1:0] CountOne = ROB_WIDTH'(32'd1);

    rob_state_e           state_q;
    rob_state_e           state_d;
    logic [ROB_WIDTH-1:0] count_q;
    logic [ROB_WIDTH-1:0] count_d;
    logic [ROB_WIDTH-1:0] head_s;
    logic [ROB_WIDTH-1:0] tail_s;

    logic [Depth-1:0]      valid_q;
    logic [Depth-1:0]      ready_q;
    logic [Depth-1:0]      branch_q;
    logic [Depth-1:0]      pred_q;
    logic [Depth-1:0]      taken_q;
    logic [REG_WIDTH-1:0]  rd_q        [Depth];
    logic [DATA_WIDTH-1:0] ent_value_q [Depth];
    logic [ADDR_WIDTH-1:0] target_q    [Depth];

    logic full_s;
    logic alloc_s;
    logic commit_s;
    logic mispredict_s;
    logic flush_s;
    logic cdb_hit_s;

    logic                  commit_en_q;
    logic [REG_WIDTH-1:0]  commit_rd_q;
    logic [DATA_WIDTH-1:0] commit_value_q;
    logic [ROB_WIDTH-1:0]  commit_tag_q;
    logic                  flush_rst_q;
    logic [ADDR_WIDTH-1:0] flush_pc_q;
    logic [ADDR_WIDTH-1:0] redirect_pc_q;

    logic                  qs_hit_s;
    logic                  qt_hit_s;
    logic                  qs_byp_s;
    logic                  qt_byp_s;
    logic                  qs_ready_s;
    logic                  qt_ready_s;
    logic [DATA_WIDTH-1:0] qs_value_s;
    logic [DATA_WIDTH-1:0] qt_value_s;

    rob_tag_ptr #(.W(ROB_WIDTH)) u_head (
        .clk_i (clk_in),
        .rst_i (rst_in),
        .clr_i (flush_s),
        .inc_i (commit_s),
        .ptr_o (head_s)
    );

    rob_tag_ptr #(.W(ROB_WIDTH)) u_tail (
        .clk_i (clk_in),
        .rst_i (rst_in),
        .clr_i (flush_s),
        .inc_i (alloc_s),
        .ptr_o (tail_s)
    );

    // Per-cycle control decisions; everything is gated by rdy_in.
    always_comb begin
        full_s       = (count_q == Capacity) || (state_q == ST_FLUSH);
        alloc_s      = rdy_in && dispatcher_rob_en_in && !full_s;
        commit_s     = rdy_in && (state_q == ST_RUN) && valid_q[head_s] && ready_q[head_s];
        mispredict_s = commit_s && branch_q[head_s] && (taken_q[head_s] != pred_q[head_s]);
        flush_s      = rdy_in && (state_q == ST_FLUSH);
        cdb_hit_s    = rdy_in && cdb_rob_en_in && (cdb_rob_tag_in != TagNone)
                       && valid_q[cdb_rob_tag_in];
    end

    // RUN/FLUSH next state and occupancy.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_RUN:   state_d = mispredict_s ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_d = rdy_in ? ST_RUN : ST_FLUSH;
            default:  state_d = ST_RUN;
        endcase
        if (flush_s) begin
            count_d = '0;
        end else if (alloc_s && !commit_s) begin
            count_d = count_q + CountOne;
        end else if (commit_s && !alloc_s) begin
            count_d = count_q - CountOne;
        end else begin
            count_d = count_q;
        end
    end

    // State and occupancy registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_RUN;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Entry storage. Allocation always lands on an invalid slot, so it never races a CDB hit.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q  <= '0;
            ready_q  <= '0;
            branch_q <= '0;
            pred_q   <= '0;
            taken_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                rd_q[i]        <= '0;
                ent_value_q[i] <= '0;
                target_q[i]    <= '0;
            end
        end else if (flush_s) begin
            valid_q <= '0;
            ready_q <= '0;
        end else begin
            if (commit_s) begin
                valid_q[head_s] <= 1'b0;
            end
            if (alloc_s) begin
                valid_q[tail_s]     <= 1'b1;
                ready_q[tail_s]     <= 1'b0;
                branch_q[tail_s]    <= dispatcher_rob_branch_in;
                pred_q[tail_s]      <= dispatcher_rob_pred_in;
                taken_q[tail_s]     <= 1'b0;
                rd_q[tail_s]        <= dispatcher_rob_rd_in;
                ent_value_q[tail_s] <= '0;
                target_q[tail_s]    <= '0;
            end
            if (cdb_hit_s) begin
                ready_q[cdb_rob_tag_in]     <= 1'b1;
                taken_q[cdb_rob_tag_in]     <= cdb_rob_taken_in;
                ent_value_q[cdb_rob_tag_in] <= cdb_rob_value_in;
                target_q[cdb_rob_tag_in]    <= cdb_rob_target_in;
            end
        end
    end

    // Registered commit/flush outputs. The redirect pc is latched at the mispredict
    // commit and presented one cycle later, so the rd write never meets rst_out.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            commit_en_q    <= 1'b0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_tag_q   <= '0;
            flush_rst_q    <= 1'b0;
            flush_pc_q     <= '0;
            redirect_pc_q  <= '0;
        end else if (!rdy_in) begin
            commit_en_q <= 1'b0;
            flush_rst_q <= 1'b0;
        end else begin
            commit_en_q <= commit_s && (rd_q[head_s] != '0);
            flush_rst_q <= flush_s;
            if (commit_s) begin
                commit_rd_q    <= rd_q[head_s];
                commit_value_q <= ent_value_q[head_s];
                commit_tag_q   <= head_s;
            end
            if (mispredict_s) begin
                flush_pc_q <= target_q[head_s];
            end
            if (flush_s) begin
                redirect_pc_q <= flush_pc_q;
            end
        end
    end

    // Operand queries; tag 0 and invalid entries read as not ready with value 0.
    always_comb begin
        qs_hit_s = (dispatcher_rob_qs_in != TagNone) && valid_q[dispatcher_rob_qs_in];
        qt_hit_s = (dispatcher_rob_qt_in != TagNone) && valid_q[dispatcher_rob_qt_in];
`ifdef ROB_BYPASS_EN
        qs_byp_s = qs_hit_s && cdb_rob_en_in && (cdb_rob_tag_in == dispatcher_rob_qs_in);
        qt_byp_s = qt_hit_s && cdb_rob_en_in && (cdb_rob_tag_in == dispatcher_rob_qt_in);
`else
        qs_byp_s = 1'b0;
        qt_byp_s = 1'b0;
`endif
        qs_ready_s = qs_byp_s || (qs_hit_s && ready_q[dispatcher_rob_qs_in]);
        qt_ready_s = qt_byp_s || (qt_hit_s && ready_q[dispatcher_rob_qt_in]);
        qs_value_s = qs_byp_s ? cdb_rob_value_in
                   : (qs_ready_s ? ent_value_q[dispatcher_rob_qs_in] : '0);
        qt_value_s = qt_byp_s ? cdb_rob_value_in
                   : (qt_ready_s ? ent_value_q[dispatcher_rob_qt_in] : '0);
    end

    assign rob_dispatcher_full_out     = full_s;
    assign rob_dispatcher_tag_out      = tail_s;
    assign rob_dispatcher_qs_ready_out = qs_ready_s;
    assign rob_dispatcher_qs_value_out = qs_value_s;
    assign rob_dispatcher_qt_ready_out = qt_ready_s;
    assign rob_dispatcher_qt_value_out = qt_value_s;
    assign rob_regfile_en_out          = commit_en_q;
    assign rob_regfile_d_out           = commit_rd_q;
    assign rob_regfile_value_out       = commit_value_q;
    assign rob_regfile_h_out           = commit_tag_q;
    assign rob_regfile_rst_out         = flush_rst_q;
    assign rob_fetcher_pc_out          = redirect_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (default ROB_WIDTH=4).
module tb_reorder_buffer;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        dispatcher_rob_en_in;
    logic [4:0]  dispatcher_rob_rd_in;
    logic        dispatcher_rob_branch_in;
    logic        dispatcher_rob_pred_in;
    logic        rob_dispatcher_full_out;
    logic [3:0]  rob_dispatcher_tag_out;
    logic [3:0]  dispatcher_rob_qs_in;
    logic        rob_dispatcher_qs_ready_out;
    logic [31:0] rob_dispatcher_qs_value_out;
    logic [3:0]  dispatcher_rob_qt_in;
    logic        rob_dispatcher_qt_ready_out;
    logic [31:0] rob_dispatcher_qt_value_out;
    logic        cdb_rob_en_in;
    logic [3:0]  cdb_rob_tag_in;
    logic [31:0] cdb_rob_value_in;
    logic        cdb_rob_taken_in;
    logic [31:0] cdb_rob_target_in;
    logic        rob_regfile_en_out;
    logic [4:0]  rob_regfile_d_out;
    logic [31:0] rob_regfile_value_out;
    logic [3:0]  rob_regfile_h_out;
    logic        rob_regfile_rst_out;
    logic [31:0] rob_fetcher_pc_out;

    int errors = 0;
    int checks = 0;

`ifdef ROB_BYPASS_EN
    localparam logic BypassOn = 1'b1;
`else
    localparam logic BypassOn = 1'b0;
`endif

    reorder_buffer dut (
        .clk_in                      (clk_in),
        .rst_in                      (rst_in),
        .rdy_in                      (rdy_in),
        .dispatcher_rob_en_in        (dispatcher_rob_en_in),
        .dispatcher_rob_rd_in        (dispatcher_rob_rd_in),
        .dispatcher_rob_branch_in    (dispatcher_rob_branch_in),
        .dispatcher_rob_pred_in      (dispatcher_rob_pred_in),
        .rob_dispatcher_full_out     (rob_dispatcher_full_out),
        .rob_dispatcher_tag_out      (rob_dispatcher_tag_out),
        .dispatcher_rob_qs_in        (dispatcher_rob_qs_in),
        .rob_dispatcher_qs_ready_out (rob_dispatcher_qs_ready_out),
        .rob_dispatcher_qs_value_out (rob_dispatcher_qs_value_out),
        .dispatcher_rob_qt_in        (dispatcher_rob_qt_in),
        .rob_dispatcher_qt_ready_out (rob_dispatcher_qt_ready_out),
        .rob_dispatcher_qt_value_out (rob_dispatcher_qt_value_out),
        .cdb_rob_en_in               (cdb_rob_en_in),
        .cdb_rob_tag_in              (cdb_rob_tag_in),
        .cdb_rob_value_in            (cdb_rob_value_in),
        .cdb_rob_taken_in            (cdb_rob_taken_in),
        .cdb_rob_target_in           (cdb_rob_target_in),
        .rob_regfile_en_out          (rob_regfile_en_out),
        .rob_regfile_d_out           (rob_regfile_d_out),
        .rob_regfile_value_out       (rob_regfile_value_out),
        .rob_regfile_h_out           (rob_regfile_h_out),
        .rob_regfile_rst_out         (rob_regfile_rst_out),
        .rob_fetcher_pc_out          (rob_fetcher_pc_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic alloc(input logic [4:0] rd, input logic br, input logic pr);
        dispatcher_rob_en_in     = 1'b1;
        dispatcher_rob_rd_in     = rd;
        dispatcher_rob_branch_in = br;
        dispatcher_rob_pred_in   = pr;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] val,
                       input logic tk, input logic [31:0] tgt);
        cdb_rob_en_in     = 1'b1;
        cdb_rob_tag_in    = tag;
        cdb_rob_value_in  = val;
        cdb_rob_taken_in  = tk;
        cdb_rob_target_in = tgt;
    endtask

    task automatic commit_chk(input string tag, input logic en, input logic [4:0] d,
                              input logic [31:0] v, input logic [3:0] h);
        chk({tag, ".en"}, 64'(rob_regfile_en_out), 64'(en));
        chk({tag, ".d"}, 64'(rob_regfile_d_out), 64'(d));
        chk({tag, ".value"}, 64'(rob_regfile_value_out), 64'(v));
        chk({tag, ".h"}, 64'(rob_regfile_h_out), 64'(h));
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        dispatcher_rob_en_in = 1'b0;
        dispatcher_rob_rd_in = 5'd0;
        dispatcher_rob_branch_in = 1'b0;
        dispatcher_rob_pred_in = 1'b0;
        dispatcher_rob_qs_in = 4'd0;
        dispatcher_rob_qt_in = 4'd0;
        cdb_rob_en_in = 1'b0;
        cdb_rob_tag_in = 4'd0;
        cdb_rob_value_in = 32'd0;
        cdb_rob_taken_in = 1'b0;
        cdb_rob_target_in = 32'd0;
        #12;
        chk("reset.tag", 64'(rob_dispatcher_tag_out), 64'd1);
        chk("reset.full", 64'(rob_dispatcher_full_out), 64'd0);
        chk("reset.rst_out", 64'(rob_regfile_rst_out), 64'd0);
        chk("reset.pc", 64'(rob_fetcher_pc_out), 64'd0);
        commit_chk("reset", 1'b0, 5'd0, 32'd0, 4'd0);
        rst_in = 1'b0;
        tick();

        // Out-of-order completion, in-order retirement.
        alloc(5'd5, 1'b0, 1'b0);
        chk("ooo.tag1", 64'(rob_dispatcher_tag_out), 64'd1);
        tick();
        alloc(5'd6, 1'b0, 1'b0);
        chk("ooo.tag2", 64'(rob_dispatcher_tag_out), 64'd2);
        tick();
        alloc(5'd7, 1'b0, 1'b0);
        chk("ooo.tag3", 64'(rob_dispatcher_tag_out), 64'd3);
        tick();
        dispatcher_rob_en_in = 1'b0;
        dispatcher_rob_qs_in = 4'd1;
        #1;
        chk("ooo.qs1_notready", 64'(rob_dispatcher_qs_ready_out), 64'd0);
        cdb(4'd3, 32'h11, 1'b0, 32'd0);
        tick();
        dispatcher_rob_qt_in = 4'd3;
        cdb(4'd1, 32'h22, 1'b0, 32'd0);
        #1;
        chk("ooo.qt3_ready", 64'(rob_dispatcher_qt_ready_out), 64'd1);
        chk("ooo.qt3_value", 64'(rob_dispatcher_qt_value_out), 64'h11);
        tick();
        cdb(4'd2, 32'h33, 1'b0, 32'd0);
        tick();
        cdb_rob_en_in = 1'b0;
        commit_chk("ooo.c1", 1'b1, 5'd5, 32'h22, 4'd1);
        tick();
        commit_chk("ooo.c2", 1'b1, 5'd6, 32'h33, 4'd2);
        tick();
        commit_chk("ooo.c3", 1'b1, 5'd7, 32'h11, 4'd3);
        tick();
        chk("ooo.idle_en", 64'(rob_regfile_en_out), 64'd0);
        chk("ooo.tag4", 64'(rob_dispatcher_tag_out), 64'd4);

        // Query bypass timing and rd=0 commit.
        alloc(5'd0, 1'b0, 1'b0);
        tick();
        dispatcher_rob_en_in = 1'b0;
        dispatcher_rob_qs_in = 4'd4;
        cdb(4'd4, 32'hABCD, 1'b0, 32'd0);
        #1;
        chk("byp.same_ready", 64'(rob_dispatcher_qs_ready_out), 64'(BypassOn));
        chk("byp.same_value", 64'(rob_dispatcher_qs_value_out), BypassOn ? 64'hABCD : 64'd0);
        tick();
        cdb_rob_en_in = 1'b0;
        #1;
        chk("byp.next_ready", 64'(rob_dispatcher_qs_ready_out), 64'd1);
        chk("byp.next_value", 64'(rob_dispatcher_qs_value_out), 64'hABCD);
        tick();
        commit_chk("byp.c4", 1'b0, 5'd0, 32'hABCD, 4'd4);
        chk("byp.retired_ready", 64'(rob_dispatcher_qs_ready_out), 64'd0);
        chk("byp.retired_value", 64'(rob_dispatcher_qs_value_out), 64'd0);

        // Asynchronous reset in the middle of operation.
        alloc(5'd1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        dispatcher_rob_en_in = 1'b0;
        chk("mid.tag8", 64'(rob_dispatcher_tag_out), 64'd8);
        rst_in = 1'b1;
        #1;
        commit_chk("mid.rst", 1'b0, 5'd0, 32'd0, 4'd0);
        chk("mid.tag", 64'(rob_dispatcher_tag_out), 64'd1);
        chk("mid.full", 64'(rob_dispatcher_full_out), 64'd0);
        #1;
        rst_in = 1'b0;
        tick();

        // Fill to capacity; the 16th allocation is ignored.
        for (int i = 1; i <= 15; i++) begin
            alloc(5'(i), 1'b0, 1'b0);
            chk($sformatf("fill.tag%0d", i), 64'(rob_dispatcher_tag_out), 64'(i));
            tick();
        end
        alloc(5'd31, 1'b0, 1'b0);
        #1;
        chk("fill.full", 64'(rob_dispatcher_full_out), 64'd1);
        tick();
        dispatcher_rob_en_in = 1'b0;
        chk("fill.full_hold", 64'(rob_dispatcher_full_out), 64'd1);
        chk("fill.tail_wrap", 64'(rob_dispatcher_tag_out), 64'd1);
        chk("fill.no_commit", 64'(rob_regfile_en_out), 64'd0);

        // Drain 1..14, then wrap the tail to tag 1 behind head 15.
        for (int k = 1; k <= 14; k++) begin
            cdb(4'(k), 32'h100 * 32'(k), 1'b0, 32'd0);
            tick();
        end
        cdb_rob_en_in = 1'b0;
        commit_chk("wrap.c13", 1'b1, 5'd13, 32'hD00, 4'd13);
        tick();
        commit_chk("wrap.c14", 1'b1, 5'd14, 32'hE00, 4'd14);
        chk("wrap.tag1", 64'(rob_dispatcher_tag_out), 64'd1);
        chk("wrap.not_full", 64'(rob_dispatcher_full_out), 64'd0);
        alloc(5'd20, 1'b0, 1'b0);
        tick();
        dispatcher_rob_en_in = 1'b0;
        cdb(4'd15, 32'hF00, 1'b0, 32'd0);
        tick();
        cdb(4'd1, 32'h1111, 1'b0, 32'd0);
        tick();
        cdb_rob_en_in = 1'b0;
        commit_chk("wrap.c15", 1'b1, 5'd15, 32'hF00, 4'd15);
        tick();
        commit_chk("wrap.c1", 1'b1, 5'd20, 32'h1111, 4'd1);
        tick();
        chk("wrap.idle_en", 64'(rob_regfile_en_out), 64'd0);
        chk("wrap.tag2", 64'(rob_dispatcher_tag_out), 64'd2);

        // Mispredicted branch at tag 2; younger tag 3 is squashed.
        alloc(5'd0, 1'b1, 1'b0);
        tick();
        alloc(5'd9, 1'b0, 1'b0);
        tick();
        dispatcher_rob_en_in = 1'b0;
        cdb(4'd3, 32'h99, 1'b0, 32'd0);
        tick();
        cdb(4'd2, 32'd0, 1'b1, 32'h1040);
        tick();
        cdb_rob_en_in = 1'b0;
        cdb_rob_taken_in = 1'b0;
        cdb_rob_target_in = 32'd0;
        tick();
        chk("mp.en", 64'(rob_regfile_en_out), 64'd0);
        chk("mp.h", 64'(rob_regfile_h_out), 64'd2);
        chk("mp.rst_early", 64'(rob_regfile_rst_out), 64'd0);
        chk("mp.full_flush", 64'(rob_dispatcher_full_out), 64'd1);
        alloc(5'd3, 1'b0, 1'b0);
        tick();
        dispatcher_rob_en_in = 1'b0;
        chk("mp.rst_out", 64'(rob_regfile_rst_out), 64'd1);
        chk("mp.pc", 64'(rob_fetcher_pc_out), 64'h1040);
        chk("mp.en_flush", 64'(rob_regfile_en_out), 64'd0);
        chk("mp.tag_after", 64'(rob_dispatcher_tag_out), 64'd1);
        chk("mp.full_after", 64'(rob_dispatcher_full_out), 64'd0);
        dispatcher_rob_qs_in = 4'd3;
        tick();
        chk("mp.rst_drop", 64'(rob_regfile_rst_out), 64'd0);
        chk("mp.no_c3", 64'(rob_regfile_en_out), 64'd0);
        chk("mp.q3_gone", 64'(rob_dispatcher_qs_ready_out), 64'd0);
        tick();
        chk("mp.no_c3_later", 64'(rob_regfile_en_out), 64'd0);

        // rdy_in low freezes allocation and commit.
        alloc(5'd4, 1'b0, 1'b0);
        tick();
        dispatcher_rob_en_in = 1'b0;
        cdb(4'd1, 32'h44, 1'b0, 32'd0);
        tick();
        cdb_rob_en_in = 1'b0;
        rdy_in = 1'b0;
        alloc(5'd7, 1'b0, 1'b0);
        tick();
        chk("rdy.hold_en", 64'(rob_regfile_en_out), 64'd0);
        chk("rdy.hold_tag", 64'(rob_dispatcher_tag_out), 64'd2);
        dispatcher_rob_en_in = 1'b0;
        tick();
        chk("rdy.hold_en2", 64'(rob_regfile_en_out), 64'd0);
        rdy_in = 1'b1;
        tick();
        commit_chk("rdy.c1", 1'b1, 5'd4, 32'h44, 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
